// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared op and port encodings for the stack arbiter
package stack_arb_pkg;
  typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} op_e;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/stack_arbiter_lifo_core.sv
// lifo_core: LIFO storage with occupancy count and registered pop data
module lifo_core
  import stack_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rdata;
  logic [AW-1:0]     w_rd_idx;
  assign w_rd_idx = AW'(r_count - CNT_W'(1));
  // storage is deliberately left unreset; only pointers and flags clear
  always_ff @(posedge clk)
    if (i_push) r_mem[r_count[AW-1:0]] <= i_wdata;
  // occupancy and read-data register; an errored op zeroes the read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      r_count <= i_push ? r_count + CNT_W'(1) : i_pop ? r_count - CNT_W'(1) : r_count;
      r_rdata <= i_pop ? r_mem[w_rd_idx] : i_clr ? '0 : r_rdata;
    end
  assign o_rdata = r_rdata;
  assign o_count = r_count;
  assign o_full  = r_count == CNT_W'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: two-port round-robin access to a shared LIFO (STACK_ARB_ERR_EN grants and flags ineligible ops)
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  port_e             r_rr_last, r_owner;
  logic              r_rvalid, r_err;
  logic              w_a_elig, w_b_elig, w_any, w_push, w_pop, w_err_op;
  op_e               w_op;
  logic [DATA_W-1:0] w_wdata, w_rdata;
`ifdef STACK_ARB_ERR_EN
  assign w_a_elig = a_req;
  assign w_b_elig = b_req;
  assign w_err_op = w_any & (w_op == OP_POP ? empty : full);
`else
  assign w_a_elig = a_req & (a_op == OP_POP ? !empty : !full);
  assign w_b_elig = b_req & (b_op == OP_POP ? !empty : !full);
  assign w_err_op = 1'b0;
`endif
  assign a_gnt   = w_a_elig & (!w_b_elig | r_rr_last == PORT_B);
  assign b_gnt   = w_b_elig & !a_gnt;
  assign w_any   = a_gnt | b_gnt;
  assign w_op    = a_gnt ? op_e'(a_op) : op_e'(b_op);
  assign w_wdata = a_gnt ? a_wdata : b_wdata;
  assign w_push  = w_any & w_op == OP_PUSH & !full;
  assign w_pop   = w_any & w_op == OP_POP & !empty;
  lifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_err_op),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );
  // last winner, response owner and the one-cycle response/err pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr_last <= PORT_B;
      r_owner   <= PORT_A;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rr_last <= a_gnt ? PORT_A : b_gnt ? PORT_B : r_rr_last;
      r_owner   <= (w_pop | w_err_op) ? (a_gnt ? PORT_A : PORT_B) : r_owner;
      r_rvalid  <= w_pop | w_err_op;
      r_err     <= w_err_op;
    end
  assign a_rvalid = r_rvalid & r_owner == PORT_A;
  assign b_rvalid = r_rvalid & r_owner == PORT_B;
  assign a_err    = r_err & r_owner == PORT_A;
  assign b_err    = r_err & r_owner == PORT_B;
  assign a_rdata  = r_owner == PORT_A ? w_rdata : '0;
  assign b_rdata  = r_owner == PORT_B ? w_rdata : '0;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed self-checking bench for stack_arbiter (honours STACK_ARB_ERR_EN)
module tb_stack_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_op, b_req, b_op;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       full, empty;
  logic [3:0] count;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  stack_arbiter #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .full(full), .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic port, input logic op, input logic [7:0] d);
    int n = 0;
    if (port) begin b_req = 1; b_op = op; b_wdata = d; end
    else begin a_req = 1; a_op = op; a_wdata = d; end
    #1;
    while (!(port ? b_gnt : a_gnt) && n < 20) begin tick(); n++; end
    chk("xfer_gnt", port ? b_gnt : a_gnt, 1);
    tick();
    a_req = 0;
    b_req = 0;
  endtask
  task automatic do_reset;
    rst_n = 0;
    a_req = 0; b_req = 0; a_op = 0; b_op = 0; a_wdata = 0; b_wdata = 0;
    tick();
    tick();
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid, a_err, b_err}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_flags", {count, empty, full}, {4'd0, 1'b1, 1'b0});
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    xfer(0, 0, 8'h11);
    xfer(0, 0, 8'h22);
    xfer(0, 0, 8'h33);
    chk("cnt3", count, 3);
    xfer(0, 1, 0);
    chk("pop33", {a_rvalid, a_rdata, b_rvalid}, {1'b1, 8'h33, 1'b0});
    xfer(0, 1, 0);
    chk("pop22", {a_rvalid, a_rdata}, {1'b1, 8'h22});
    xfer(0, 1, 0);
    chk("pop11", {a_rvalid, a_rdata, empty}, {1'b1, 8'h11, 1'b1});
    tick();
    chk("rdata_hold", {a_rvalid, a_rdata}, {1'b0, 8'h11});
    do_reset();
    a_req = 1; b_req = 1; a_op = 0; b_op = 0; a_wdata = 8'hA0; b_wdata = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (k % 2 == 0) a_wdata++; else b_wdata++;
    end
    a_req = 0; b_req = 0;
    chk("rr_full", {count, full}, {4'd8, 1'b1});
    exp_q = '{8'hB3, 8'hA3, 8'hB2, 8'hA2, 8'hB1, 8'hA1, 8'hB0, 8'hA0};
    foreach (exp_q[i]) begin
      xfer(0, 1, 0);
      chk("rr_pop", a_rdata, exp_q[i]);
    end
    for (int i = 1; i <= 8; i++) xfer(0, 0, 8'(i));
    chk("fill", {count, full}, {4'd8, 1'b1});
    a_req = 1; a_op = 0; a_wdata = 8'hFF;
`ifdef STACK_ARB_ERR_EN
    #1;
    chk("full_push_gnt", a_gnt, 1);
    tick();
    a_req = 0;
    chk("full_push_err", {a_rvalid, a_err, a_rdata, count}, {1'b1, 1'b1, 8'h00, 4'd8});
`else
    repeat (3) begin
      #1;
      chk("full_stall", a_gnt, 0);
      tick();
    end
    b_req = 1; b_op = 1;
    #1;
    chk("full_bpop_gnt", {a_gnt, b_gnt}, 2'b01);
    tick();
    b_req = 0;
    chk("full_bpop", {b_rvalid, b_rdata, b_err, count}, {1'b1, 8'h08, 1'b0, 4'd7});
    #1;
    chk("full_unstall", a_gnt, 1);
    tick();
    a_req = 0;
    chk("refill", count, 8);
`endif
    for (int i = 0; i < 10 && count != 0; i++) xfer(0, 1, 0);
    chk("drained", {count, empty}, {4'd0, 1'b1});
    b_req = 1; b_op = 1;
`ifdef STACK_ARB_ERR_EN
    #1;
    chk("empty_pop_gnt", b_gnt, 1);
    tick();
    b_req = 0;
    chk("empty_pop_err", {b_rvalid, b_err, b_rdata, count}, {1'b1, 1'b1, 8'h00, 4'd0});
    xfer(0, 0, 8'h5A);
    xfer(1, 1, 0);
`else
    repeat (2) begin
      #1;
      chk("empty_stall", b_gnt, 0);
      tick();
    end
    a_req = 1; a_op = 0; a_wdata = 8'h5A;
    #1;
    chk("unblock_push", {a_gnt, b_gnt}, 2'b10);
    tick();
    a_req = 0;
    #1;
    chk("unblock_pop_gnt", b_gnt, 1);
    tick();
    b_req = 0;
`endif
    chk("b_gets_5a", {b_rvalid, b_rdata, b_err}, {1'b1, 8'h5A, 1'b0});
    xfer(0, 0, 8'h07);
    a_req = 1; a_op = 0; a_wdata = 8'h42; b_req = 1; b_op = 1;
    #1;
    chk("clash_b_wins", {a_gnt, b_gnt}, 2'b01);
    tick();
    b_req = 0;
    chk("clash_b_data", {b_rvalid, b_rdata, count}, {1'b1, 8'h07, 4'd0});
    #1;
    chk("clash_a_next", {a_gnt, b_gnt}, 2'b10);
    tick();
    a_req = 0;
    chk("clash_cnt", count, 1);
    xfer(0, 1, 0);
    chk("clash_a_pop", {a_rvalid, a_rdata, empty}, {1'b1, 8'h42, 1'b1});
    xfer(0, 0, 8'h33);
    xfer(0, 1, 0);
    rst_n = 0;
    #1;
    chk("midrst", {a_rvalid, b_rvalid, count, empty}, {1'b0, 1'b0, 4'd0, 1'b1});
    tick();
    rst_n = 1;
    chk("midrst_rdata", {a_rvalid, a_rdata}, {1'b0, 8'h00});
    b_req = 1; b_op = 1;
    #1;
`ifdef STACK_ARB_ERR_EN
    chk("post_rst_empty_pop", b_gnt, 1);
    tick();
    b_req = 0;
    chk("post_rst_err", {b_rvalid, b_err}, 2'b11);
    b_req = 1;
    #1;
`else
    chk("post_rst_empty_pop", b_gnt, 0);
`endif
    a_req = 1; a_op = 0; a_wdata = 8'h01;
    #1;
    chk("post_rst_a_prio", {a_gnt, b_gnt}, 2'b10);
    tick();
    a_req = 0; b_req = 0;
    chk("post_rst_cnt", count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
